// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins ties, bounded by a streak counter so fetch cannot starve.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  state_t        state, nstate;
  logic [SW-1:0] streak, nstreak;
  logic          dreq;
  logic          iack;
  logic          dack;

  assign dreq  = dREN | dWEN;
  assign iack  = (state == IGRANT) && iREN && (ramstate == ACCESS);
  assign dack  = (state == DGRANT) && dreq && (ramstate == ACCESS);
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= nstate;
      streak <= nstreak;
    end
  end

  always_comb begin
    nstate  = state;
    nstreak = streak;
    unique case (state)
      IDLE: begin
        if (dreq && (!iREN || streak < SMAX))
          nstate = DGRANT;
        else if (iREN)
          nstate = IGRANT;
      end
      IGRANT: begin
        if (!iREN) begin
          nstate = IDLE;
        end else if (iack) begin
          nstate  = IDLE;
          nstreak = '0;
        end
      end
      DGRANT: begin
        if (!dreq) begin
          nstate = IDLE;
        end else if (dack) begin
          nstate = IDLE;
          if (!iREN)
            nstreak = '0;
          else if (streak != SMAX)
            nstreak = streak + SW'(1);
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // enables follow the live request so a dropped request aborts at once
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    mem_err  = 1'b0;
    unique case (state)
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !iack;
        mem_err = iREN && (ramstate == ERROR);
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !dack;
        mem_err  = dreq && (ramstate == ERROR);
      end
      default: ;
    endcase
  end

endmodule
